// File: rtl/prod_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_pkg
// Description : Shared types and constants for the product accumulator.
//               state_t : controller states (IDLE / ACCUM / DONE), 2 bits.
//               ACC_RESET : clear value for the accumulator (all zeros),
//                           wide enough to be sliced to any WIDTH <= 128.
// Revision    : 1.0 - initial release
// ============================================================================
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [127:0] ACC_RESET = '0;

endpackage : prod_accum_pkg
`default_nettype wire

// File: rtl/accum_datapath.sv
`default_nettype none
// ============================================================================
// Module      : accum_datapath
// Description : WIDTH-bit accumulator register plus sticky unsigned carry flag.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : zero the accumulator and carry flag (priority over en)
//   en        : add in_data into the accumulator this cycle
//   in_data   : addend
//   sum_next  : acc + in_data (value acc takes when en is high)
//   ovf_next  : ovf | carry   (value ovf takes when en is high)
// Revision    : 1.0 - initial release
// ============================================================================
module accum_datapath
  import prod_accum_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] sum_next,
  output logic             ovf_next
);

  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  adder_nbit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign sum_next = w_sum;
  assign ovf_next = r_ovf | w_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= ACC_RESET[WIDTH-1:0];
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_acc <= ACC_RESET[WIDTH-1:0];
      r_ovf <= 1'b0;
    end else if (en) begin
      r_acc <= w_sum;
      r_ovf <= ovf_next;
    end
  end

endmodule : accum_datapath
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
// ============================================================================
// Module      : adder_nbit
// Description : Unsigned WIDTH-bit ripple/inferred adder with carry in/out.
//   a, b  : operands (WIDTH)
//   cin   : carry in
//   sum   : a + b + cin truncated to WIDTH
//   cout  : carry out of the top bit
// Revision    : 1.0 - initial release
// ============================================================================
module adder_nbit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule : adder_nbit
`default_nettype wire

// File: rtl/prod_accum_int64.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_int64
// Description : Dot-product accumulator for the 64-bit multiplier product
//               stream. A job of len products is summed modulo 2^WIDTH and
//               returned on a valid/ready output with a sticky carry flag.
//   clk, rst            : clock, asynchronous active-high reset
//   start, len          : job request (sampled in IDLE only), product count
//   busy                : state != IDLE
//   in_valid/in_ready   : product handshake, in_data = product
//   out_valid/out_ready : result handshake
//   out_sum, out_ovf    : result and unsigned carry flag; hold last values
// Revision    : 1.0 - initial release
// ============================================================================
module prod_accum_int64
  import prod_accum_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_ovf;

  logic             w_hs;
  logic             w_last;
  logic             w_clr;
  logic             w_len_zero;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_ovf_next;

  // in_ready comes purely from the state register, so the handshake has no
  // combinational path from in_valid back to in_ready.
  assign in_ready   = (r_state == ACCUM);
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);

  assign w_hs       = in_valid && in_ready;
  assign w_last     = w_hs && (r_cnt == LEN_W'(1));
  assign w_clr      = (r_state == IDLE) && start;
  assign w_len_zero = (len == '0);

  accum_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .en       (w_hs),
    .in_data  (in_data),
    .sum_next (w_sum_next),
    .ovf_next (w_ovf_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = w_len_zero ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Remaining-product down-counter; only loaded in IDLE, so start during a
  // job cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_clr && !w_len_zero) begin
      r_cnt <= len;
    end else if (w_hs) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  // Result registers are loaded only on entry to DONE. The accumulator is
  // cleared at job start, so presenting it directly would not hold the
  // previous result while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sum <= ACC_RESET[WIDTH-1:0];
      r_out_ovf <= 1'b0;
    end else if (w_last) begin
      r_out_sum <= w_sum_next;
      r_out_ovf <= w_ovf_next;
    end else if (w_clr && w_len_zero) begin
      r_out_sum <= ACC_RESET[WIDTH-1:0];
      r_out_ovf <= 1'b0;
    end
  end

  assign out_sum = r_out_sum;
  assign out_ovf = r_out_ovf;

endmodule : prod_accum_int64
`default_nettype wire

// File: tb/tb_prod_accum_int64.sv
`default_nettype none
// ============================================================================
// Module      : tb_prod_accum_int64
// Description : Self-checking bench for prod_accum_int64. Expected results
//               come from a bench-side sum/carry model and sit in a queue
//               until the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prod_accum_int64;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_ovf;

  int          n_checks;
  int          n_fail;
  exp_t        sb[$];
  exp_t        exp_r;
  logic [63:0] m_sum;
  logic        m_ovf;

  prod_accum_int64 #(
    .WIDTH (64),
    .LEN_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input logic [63:0] d);
    logic [64:0] t;
    t     = {1'b0, m_sum} + {1'b0, d};
    m_sum = t[63:0];
    m_ovf = m_ovf | t[64];
  endtask

  task automatic start_job(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    m_sum = '0;
    m_ovf = 1'b0;
  endtask

  task automatic feed(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    model_add(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sum !== 64'd0) begin n_fail++; $display("FAIL reset_out_sum: got %h expected 0", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start_job(16'd3);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    feed(64'd5);
    feed(64'd7);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    feed(64'd11);
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
    if (sb.size() != 0) begin
      exp_r = sb.pop_front();
      n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL basic_sum: got %h expected %h", out_sum, exp_r.sum); end
      n_checks++; if (out_ovf !== exp_r.ovf) begin n_fail++; $display("FAIL basic_ovf: got %b expected %b", out_ovf, exp_r.ovf); end
    end
    n_checks++; if (out_sum !== 64'd23) begin n_fail++; $display("FAIL basic_sum_const: got %h expected 23", out_sum); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    n_checks++; if (out_sum !== 64'd23) begin n_fail++; $display("FAIL basic_sum_hold: got %h expected 23", out_sum); end
  endtask

  task automatic test_overflow();
    start_job(16'd2);
    feed(64'hFFFF_FFFF_FFFF_FFFF);
    feed(64'h2);
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", out_valid); end
    exp_r = sb.pop_front();
    n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL ovf_sum: got %h expected %h", out_sum, exp_r.sum); end
    n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", out_ovf); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start_job(16'd1);
    feed(64'd4);
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf2_valid: got %b expected 1", out_valid); end
    exp_r = sb.pop_front();
    n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL ovf2_sum: got %h expected %h", out_sum, exp_r.sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf2_sticky_clear: got %b expected 0", out_ovf); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    start_job(16'd0);
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
    exp_r = sb.pop_front();
    n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL zero_sum: got %h expected %h", out_sum, exp_r.sum); end
    n_checks++; if (out_ovf !== exp_r.ovf) begin n_fail++; $display("FAIL zero_ovf: got %b expected %b", out_ovf, exp_r.ovf); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [5:0]  vpat;
    logic [63:0] prods [4];
    int          k;
    vpat  = 6'b110101;  // bit i drives beat i: 1,0,1,0,1,1
    prods = '{64'd100, 64'd200, 64'd300, 64'd400};
    k     = 0;
    start_job(16'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = vpat[i];
      in_data  = vpat[i] ? prods[k] : 64'hDEAD_BEEF;
      if (vpat[i]) begin
        model_add(prods[k]);
        k++;
      end
      tick();
    end
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    // Offer a stray product during DONE; it must not be consumed.
    in_valid = 1'b1;
    in_data  = 64'h55;
    exp_r    = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, out_valid); end
      n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL stall_sum[%0d]: got %h expected %h", c, out_sum, exp_r.sum); end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (out_sum !== 64'd1000) begin n_fail++; $display("FAIL stall_sum_const: got %h expected 1000", out_sum); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    start_job(16'd4);
    feed(64'd1);
    feed(64'd2);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sum !== 64'd0) begin n_fail++; $display("FAIL rmid_out_sum: got %h expected 0", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_out_ovf: got %b expected 0", out_ovf); end
    #2;
    rst = 1'b0;
    tick();
    start_job(16'd1);
    feed(64'd9);
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid2_valid: got %b expected 1", out_valid); end
    exp_r = sb.pop_front();
    n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL rmid2_sum: got %h expected %h", out_sum, exp_r.sum); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    start_job(16'd2);
    start = 1'b1;
    len   = 16'd7;
    feed(64'd3);
    start = 1'b0;
    len   = 16'd0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sig_early_valid: got %b expected 0", out_valid); end
    feed(64'd4);
    sb.push_back('{sum: m_sum, ovf: m_ovf});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sig_valid: got %b expected 1", out_valid); end
    exp_r = sb.pop_front();
    n_checks++; if (out_sum !== exp_r.sum) begin n_fail++; $display("FAIL sig_sum: got %h expected %h", out_sum, exp_r.sum); end
    // start together with out_ready in DONE: only the retire is honoured.
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 16'd3;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sig_done_start_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sig_idle_stays: got %b expected 0", busy); end
  endtask

  task automatic test_scoreboard_empty();
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_empty: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_sum     = '0;
    m_ovf     = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero_len();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_scoreboard_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prod_accum_int64
`default_nettype wire
